// File: rtl/burst_rx.sv
// burst_rx: counts beats of each strobe/last burst, reports the length through
// a one-entry valid/ready holding register and pulses err on protocol violations.
// Latency: len_valid and err assert on the edge after g or the violating edge.
// Backpressure: a full report register drops the next burst and flags overrun (10).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s, g                  beat strobe and end-of-burst marker from the generator
//   len_valid/len/len_ovf report register, drained by len_ready
//   busy                  burst in progress (ACTIVE)
//   err/err_code          one-cycle violation pulse: 01 s&g, 10 overrun, 11 spacing
//   max_len               largest length reported so far (only with BURST_RX_MAXLEN_EN)
//
// Optional feature macro: BURST_RX_MAXLEN_EN adds the max_len output and register.
module burst_rx #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s,
    input  logic             g,
    output logic             len_valid,
    output logic [CNT_W-1:0] len,
    output logic             len_ovf,
    input  logic             len_ready,
    output logic             busy,
    output logic             err,
    output logic [1:0]       err_code
`ifdef BURST_RX_MAXLEN_EN
    ,
    output logic [CNT_W-1:0] max_len
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] GAP1   = 2'd2;
    localparam logic [1:0] GAP2   = 2'd3;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_SG      = 2'b01;
    localparam logic [1:0] ERR_OVERRUN = 2'b10;
    localparam logic [1:0] ERR_SPACING = 2'b11;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             ovf, ovf_nxt;

    logic             in_active;
    logic             in_gap;
    logic [CNT_W-1:0] base_cnt;
    logic             base_ovf;
    logic [CNT_W-1:0] beat_cnt;
    logic             beat_ovf;
    logic             can_load;
    logic             load;
    logic             drop;
    logic [1:0]       code_nxt;

    assign in_active = (state == ACTIVE);
    assign in_gap    = (state == GAP1) || (state == GAP2);

    // Only ACTIVE carries a running count; any other state starts a fresh burst,
    // so a beat seen there (including s&g or a spacing violation) counts from 0.
    assign base_cnt = in_active ? count : '0;
    assign base_ovf = in_active & ovf;

    // Count including this cycle's beat, saturating at all-ones.
    always_comb begin
        beat_cnt = base_cnt;
        beat_ovf = base_ovf;
        if (s) begin
            if (base_cnt == {CNT_W{1'b1}}) begin
                beat_ovf = 1'b1;
            end else begin
                beat_cnt = base_cnt + 1'b1;
            end
        end
    end

    // The holding register accepts a new report when empty or draining now.
    assign can_load = !len_valid || len_ready;
    assign load     = g && can_load;
    assign drop     = g && !can_load;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        ovf_nxt   = ovf;
        if (g) begin
            state_nxt = GAP1;
            count_nxt = '0;
            ovf_nxt   = 1'b0;
        end else if (s) begin
            state_nxt = ACTIVE;
            count_nxt = beat_cnt;
            ovf_nxt   = beat_ovf;
        end else begin
            case (state)
                GAP1:    state_nxt = GAP2;
                GAP2:    state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    // One code per cycle: overrun outranks s&g, which outranks spacing.
    always_comb begin
        code_nxt = ERR_NONE;
        if (drop) begin
            code_nxt = ERR_OVERRUN;
        end else if (s && g) begin
            code_nxt = ERR_SG;
        end else if (in_gap && (s || g)) begin
            code_nxt = ERR_SPACING;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            ovf   <= ovf_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_valid <= 1'b0;
            len       <= '0;
            len_ovf   <= 1'b0;
        end else if (load) begin
            len_valid <= 1'b1;
            len       <= beat_cnt;
            len_ovf   <= beat_ovf;
        end else if (len_ready) begin
            len_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            err      <= (code_nxt != ERR_NONE);
            err_code <= code_nxt;
        end
    end

    assign busy = in_active;

`ifdef BURST_RX_MAXLEN_EN
    logic [CNT_W-1:0] load_val;

    // A saturated burst is recorded as all-ones regardless of the held count.
    assign load_val = beat_ovf ? {CNT_W{1'b1}} : beat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_len <= '0;
        end else if (load && (load_val > max_len)) begin
            max_len <= load_val;
        end
    end
`endif

endmodule

// File: tb/tb_burst_rx.sv
// tb_burst_rx: directed stimulus for burst_rx (CNT_W=4) with a burst-level
// reference model compared every cycle plus hand-computed literal checks.
// Model tracks bursts as unbounded beat totals and a one-deep report queue.
module tb_burst_rx;

    localparam int CNT_W = 4;
    localparam int LIM   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             s = 1'b0;
    logic             g = 1'b0;
    logic             len_ready = 1'b0;
    logic             len_valid;
    logic [CNT_W-1:0] len;
    logic             len_ovf;
    logic             busy;
    logic             err;
    logic [1:0]       err_code;
`ifdef BURST_RX_MAXLEN_EN
    logic [CNT_W-1:0] max_len;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    burst_rx #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s         (s),
        .g         (g),
        .len_valid (len_valid),
        .len       (len),
        .len_ovf   (len_ovf),
        .len_ready (len_ready),
        .busy      (busy),
        .err       (err),
        .err_code  (err_code)
`ifdef BURST_RX_MAXLEN_EN
        ,
        .max_len   (max_len)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int len;
        bit ovf;
    } rep_t;

    rep_t q[$];
    bit   m_in    = 1'b0;   // inside a burst
    int   m_beats = 0;      // unbounded beat total of the current burst
    int   m_gap   = 0;      // mandatory quiet cycles still owed
    bit   m_err   = 1'b0;
    int   m_code  = 0;
    int   m_max   = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_in = 0; m_beats = 0; m_gap = 0;
            m_err = 0; m_code = 0; m_max = 0;
        end else begin
            bit   has;
            bit   full;
            bit   spacing;
            int   tot;
            int   rv;
            rep_t r;
            has     = (q.size() != 0);
            full    = has && !len_ready;
            spacing = (m_gap > 0) && (s || g);
            if (has && len_ready) void'(q.pop_front());
            m_err  = 0;
            m_code = 0;
            if (g) begin
                tot   = (m_in ? m_beats : 0) + (s ? 1 : 0);
                r.len = (tot > LIM) ? LIM : tot;
                r.ovf = (tot > LIM);
                if (full) begin
                    m_err = 1; m_code = 2;
                end else begin
                    q.push_back(r);
                    rv = r.ovf ? LIM : r.len;
                    if (rv > m_max) m_max = rv;
                    if (s) begin
                        m_err = 1; m_code = 1;
                    end else if (spacing) begin
                        m_err = 1; m_code = 3;
                    end
                end
                m_in = 0; m_beats = 0; m_gap = 2;
            end else if (s) begin
                m_beats = m_in ? m_beats + 1 : 1;
                m_in    = 1;
                m_gap   = 0;
                if (spacing) begin
                    m_err = 1; m_code = 3;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        chk("m_busy", busy, m_in);
        chk("m_len_valid", len_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("m_len", len, q[0].len);
            chk("m_len_ovf", len_ovf, q[0].ovf);
        end
        chk("m_err", err, m_err);
        if (m_err) chk("m_err_code", err_code, m_code);
`ifdef BURST_RX_MAXLEN_EN
        chk("m_max_len", max_len, m_max);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic vs, input logic vg, input logic vr);
        @(negedge clk);
        s = vs; g = vg; len_ready = vr;
        @(posedge clk);
        #1;
    endtask

    task automatic beats(input int n, input logic vr);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, vr);
    endtask

    task automatic quiet(input int n, input logic vr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, vr);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_len_valid", len_valid, 0);
        chk("rst_len", len, 0);
        chk("rst_len_ovf", len_ovf, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_err_code", err_code, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // basic burst of 5
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b1);
            chk("basic_busy", busy, 1);
        end
        step(1'b0, 1'b1, 1'b1);
        chk("basic_valid", len_valid, 1);
        chk("basic_len", len, 5);
        chk("basic_ovf", len_ovf, 0);
        chk("basic_err", err, 0);
        chk("basic_busy_end", busy, 0);
        quiet(3, 1'b1);
        chk("basic_drained", len_valid, 0);

        // zero-length burst
        step(1'b0, 1'b1, 1'b1);
        chk("zero_valid", len_valid, 1);
        chk("zero_len", len, 0);
        quiet(3, 1'b1);

        // saturation
        beats(20, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("sat_len", len, 15);
        chk("sat_ovf", len_ovf, 1);
        quiet(3, 1'b1);
        beats(3, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("post_sat_len", len, 3);
        chk("post_sat_ovf", len_ovf, 0);
        quiet(3, 1'b1);

        // backpressure and overrun
        beats(2, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        quiet(3, 1'b0);
        beats(7, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("ovr_err", err, 1);
        chk("ovr_code", err_code, 2);
        chk("ovr_len_held", len, 2);
        quiet(1, 1'b0);
        chk("ovr_err_one_cycle", err, 0);
        chk("ovr_still_valid", len_valid, 1);
        quiet(1, 1'b1);
        chk("ovr_drained", len_valid, 0);
        quiet(2, 1'b1);

        // s&g after 3 beats, then spacing violations
        beats(3, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("sg_len", len, 4);
        chk("sg_err", err, 1);
        chk("sg_code", err_code, 1);
        step(1'b1, 1'b0, 1'b1);
        chk("gap_s_code", err_code, 3);
        chk("gap_s_err", err, 1);
        chk("gap_s_busy", busy, 1);
        step(1'b0, 1'b1, 1'b1);
        chk("gap_s_len", len, 1);
        step(1'b0, 1'b1, 1'b1);
        chk("gap_g_code", err_code, 3);
        chk("gap_g_len", len, 0);
        step(1'b1, 1'b1, 1'b1);
        chk("gap_sg_code", err_code, 1);
        chk("gap_sg_len", len, 1);
        quiet(3, 1'b0);
        // overrun outranks s&g
        beats(1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("ovr_sg_code", err_code, 2);
        chk("ovr_sg_len", len, 1);
        quiet(3, 1'b1);

        // reset mid-burst with a pending report
        beats(2, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        quiet(3, 1'b0);
        beats(3, 1'b0);
        @(negedge clk);
        s = 1'b0; g = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", len_valid, 0);
        chk("mid_rst_len", len, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err, 0);
`ifdef BURST_RX_MAXLEN_EN
        chk("mid_rst_max", max_len, 0);
`endif
        @(negedge clk);
        #2 rst_n = 1'b1;
        beats(2, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("post_rst_len", len, 2);
        chk("post_rst_valid", len_valid, 1);
`ifdef BURST_RX_MAXLEN_EN
        chk("post_rst_max", max_len, 2);
`endif
        quiet(4, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/burst_rx.md
Name: burst_rx

Overview:
- Receive end of the registered strobe/last burst protocol.
- Protocol on the wire:
  - `s`: one pulse per beat, 0..N consecutive cycles.
  - `g`: one-cycle end-of-burst marker.
  - At least 2 quiet cycles follow each `g`.
- The block counts beats per burst and hands the burst length to a consumer over a valid/ready holding register.
- It flags protocol violations.
- It sits directly downstream of the burst generator FSM in the same clock domain.

Parameters:
- CNT_W, 8, width of the beat counter and the reported length; maximum reportable length is 2^CNT_W-1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- s  input  1  beat strobe from the generator
- g  input  1  end-of-burst marker from the generator
- len_valid  output  1  report register holds a burst length
- len  output  CNT_W  beat count of the reported burst
- len_ovf  output  1  reported burst exceeded 2^CNT_W-1 beats; len is saturated
- len_ready  input  1  consumer accepts the report when len_valid&len_ready
- busy  output  1  a burst is in progress (state ACTIVE)
- err  output  1  one-cycle pulse on a protocol violation
- err_code  output  2  valid only while err=1: 01 s&g same cycle, 10 report overrun, 11 spacing violation

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, count=0, ovf=0, len_valid=0, len=0, len_ovf=0, busy=0, err=0, err_code=0.
- A reset asserted mid-burst discards the count and any pending report.
- States:
  - IDLE: no burst.
  - ACTIVE: at least one beat counted.
  - GAP1, GAP2: mandatory quiet cycles after `g`.
- Transitions, sampling s/g each edge:
  - IDLE:
    - s → ACTIVE, count=1.
    - g → zero-length burst, terminate(0), GAP1.
  - ACTIVE:
    - s&!g → count+1, saturating at all-ones; ovf set when an increment is attempted at all-ones.
    - g → terminate, GAP1.
  - GAP1: → GAP2.
  - GAP2: → IDLE.
- Spacing violation in GAP1/GAP2 (err_code 11):
  - s → ACTIVE, count=1.
  - g → terminate(0), GAP1.
- s&g in the same cycle, any state:
  - The beat is counted, then the burst terminates.
  - err pulses with code 01.
  - In a GAP state, code 01 takes priority over 11.
- Terminate:
  - Loads len=count and len_ovf=ovf into the report register, sets len_valid, clears count/ovf.
  - Load occurs when the register is empty or is being drained in the same cycle (len_valid&len_ready).
  - Otherwise the new burst is dropped, the register keeps the old value, and err pulses with code 10.
  - Code 10 has priority over 01/11 when both occur; only one code per cycle.
- Latency: `g` sampled at edge t gives len_valid=1 after edge t; err likewise asserts after the violating edge for exactly one cycle.
- Handshake:
  - len/len_ovf stay stable while len_valid=1 and len_ready=0.
  - len_valid clears on the edge after len_valid&len_ready unless a simultaneous load occurs.
  - A back-to-back load plus drain keeps len_valid=1 with the new value.
- busy is 1 exactly while state=ACTIVE.
- len_ready is ignored while len_valid=0.

Optional Feature:
- Macro: BURST_RX_MAXLEN_EN.
- With the macro defined:
  - Adds output max_len [CNT_W-1:0], reset 0.
  - max_len updates to len on every successful report load whose value exceeds the current max_len.
  - Saturated (len_ovf) bursts load all-ones.
  - Dropped bursts do not update max_len.
- Without the macro: the port and register are absent and behaviour is otherwise identical.

Test Plan:
- Basic burst:
  - Stimulus: s high 5 cycles, then g 1 cycle, len_ready=1.
  - Response: busy high 5 cycles, then len_valid=1 one cycle after g with len=5, len_ovf=0, no err.
- Zero-length burst:
  - Stimulus: single g from IDLE.
  - Response: len=0, len_valid=1, state passes GAP1, GAP2, IDLE.
- Saturation (CNT_W=4):
  - Stimulus: 20 s beats, then g.
  - Response: len=15, len_ovf=1.
  - Next burst of 3 beats reports len=3, len_ovf=0.
- Backpressure and overrun:
  - Stimulus: len_ready=0; burst of 2 beats, then a burst of 7 beats.
  - Response: len=2 held, err=1 with code 10 one cycle after the second g.
  - Raising len_ready drains len=2, then len_valid=0.
- Violations:
  - Stimulus: s&g together after 3 beats.
  - Response: len=4, err code 01.
  - Stimulus: s in GAP1 right after a g.
  - Response: err code 11, busy=1, a following g reports len=1.
- Reset mid-operation:
  - Stimulus: rst_n low after 3 beats with a pending report.
  - Response: all outputs 0 immediately.
  - A post-reset burst of 2 reports len=2.
  - With BURST_RX_MAXLEN_EN defined, max_len=0 after reset, then 2.
